filter_bank_scheduler: RTL and testbench



---
 rtl/filter_sched_pkg.sv | 26 ++
 rtl/line_tag_fifo.sv | 74 +++++++
 rtl/filter_bank_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_filter_bank_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_sched_pkg
// Description : Shared types and helpers for the filter bank scheduler:
//               input FSM state encoding, requester index type and the
//               pixel word width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package filter_sched_pkg;

    // Input-side FSM: waiting for a requester, or streaming one line.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } sched_state_t;

    // Wide enough for up to four requesters.
    typedef logic [1:0] req_idx_t;

    // Pixel word = 8-bit confidence-carrying base plus the disparity field.
    function automatic int cd_width(input int disp_bits);
        return 8 + disp_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : line_tag_fifo
// Description : Small synchronous FIFO holding the owner index of each line
//               currently inside the filter bank. Supports push and pop in
//               the same cycle (occupancy unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
module line_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];

    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : filter_bank_scheduler
// Description : Time-shares one filter bank between several line sources.
//               Input side grants whole lines round-robin and forwards the
//               granted pixels; output side routes bank results back to the
//               owner of the oldest line in flight, tracked by a tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_bank_scheduler
    import filter_sched_pkg::*;
#(
    parameter  int disp_bits = 5,
    parameter  int line_len  = 120,
    parameter  int num_req   = 2,
    parameter  int tag_depth = 4,
    localparam int c_cd_w    = cd_width(disp_bits)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [num_req-1:0]              req,
    output logic [num_req-1:0]              grant,
    input  logic [num_req-1:0][c_cd_w-1:0]  src_disp_conf,
    input  logic [num_req-1:0][7:0]         src_conf,
    input  logic [num_req-1:0]              src_valid,
    output logic [c_cd_w-1:0]               bank_disp_conf_in,
    output logic [7:0]                      bank_conf_in,
    output logic                            bank_conf_in_valid,
    input  logic [c_cd_w-1:0]               bank_disp_conf_out,
    input  logic [7:0]                      bank_conf_out,
    input  logic                            bank_conf_out_valid,
    output logic [num_req-1:0][c_cd_w-1:0]  dst_disp_conf,
    output logic [num_req-1:0][7:0]         dst_conf,
    output logic [num_req-1:0]              dst_valid,
    output logic                            busy,
    output logic                            protocol_err
);

    localparam int                 c_cnt_w = (line_len > 1) ? $clog2(line_len) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(line_len - 1);

    sched_state_t                       r_state;
    logic [num_req-1:0]                 r_grant;
    req_idx_t                           r_winner;
    req_idx_t                           r_rr_ptr;
    logic [c_cnt_w-1:0]                 r_in_cnt;
    logic [c_cnt_w-1:0]                 r_out_cnt;
    logic                               r_bin_valid;
    logic [c_cd_w-1:0]                  r_bin_disp;
    logic [7:0]                         r_bin_conf;
    logic [num_req-1:0]                 r_dst_valid;
    logic [num_req-1:0][c_cd_w-1:0]     r_dst_disp;
    logic [num_req-1:0][7:0]            r_dst_conf;
    logic                               r_err;

    logic                               w_found_hi;
    logic                               w_found_lo;
    req_idx_t                           w_win_hi;
    req_idx_t                           w_win_lo;
    req_idx_t                           w_winner;
    req_idx_t                           w_rr_next;
    logic                               w_sel_valid;
    logic [c_cd_w-1:0]                  w_sel_disp;
    logic [7:0]                         w_sel_conf;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_bank_take;
    logic                               w_fifo_full;
    logic                               w_fifo_empty;
    req_idx_t                           w_head;

    // Round-robin pick: lowest requesting index at or above the pointer,
    // otherwise the lowest requesting index below it (wrap-around).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = num_req - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i >= int'(r_rr_ptr)) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = req_idx_t'(i);
                end else begin
                    w_found_lo = 1'b1;
                    w_win_lo   = req_idx_t'(i);
                end
            end
        end
        w_winner = w_found_hi ? w_win_hi : w_win_lo;
    end

    assign w_rr_next = (w_winner == req_idx_t'(num_req - 1)) ? '0 : w_winner + req_idx_t'(1);

    // Only the granted requester's strobe reaches the bank; grant is one-hot.
    always_comb begin
        w_sel_disp = '0;
        w_sel_conf = '0;
        for (int i = 0; i < num_req; i++) begin
            if (r_grant[i]) begin
                w_sel_disp = src_disp_conf[i];
                w_sel_conf = src_conf[i];
            end
        end
    end

    assign w_sel_valid = |(src_valid & r_grant);
    assign w_push      = (r_state == ST_STREAM) && w_sel_valid && (r_in_cnt == c_last);
    assign w_bank_take = bank_conf_out_valid && !w_fifo_empty;
    assign w_pop       = w_bank_take && (r_out_cnt == c_last);

    line_tag_fifo #(
        .DEPTH (tag_depth),
        .WIDTH ($bits(req_idx_t))
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (r_winner),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Input FSM: arbitrate in IDLE, stream one full line in STREAM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_winner <= '0;
            r_rr_ptr <= '0;
            r_in_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((|req) && !w_fifo_full) begin
                        r_state  <= ST_STREAM;
                        r_winner <= w_winner;
                        r_rr_ptr <= w_rr_next;
                        for (int i = 0; i < num_req; i++) begin
                            r_grant[i] <= (w_winner == req_idx_t'(i));
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_sel_valid) begin
                        if (r_in_cnt == c_last) begin
                            r_in_cnt <= '0;
                            r_grant  <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_in_cnt <= r_in_cnt + c_cnt_w'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Registered feed into the shared bank.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bin_valid <= 1'b0;
        end else begin
            r_bin_valid <= w_sel_valid;
            if (w_sel_valid) begin
                r_bin_disp <= w_sel_disp;
                r_bin_conf <= w_sel_conf;
            end
        end
    end

    // Route bank results to the owner of the oldest line in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_cnt   <= '0;
            r_dst_valid <= '0;
        end else begin
            if (w_bank_take) begin
                r_out_cnt <= (r_out_cnt == c_last) ? '0 : r_out_cnt + c_cnt_w'(1);
            end
            for (int i = 0; i < num_req; i++) begin
                r_dst_valid[i] <= w_bank_take && (w_head == req_idx_t'(i));
                if (w_bank_take && (w_head == req_idx_t'(i))) begin
                    r_dst_disp[i] <= bank_disp_conf_out;
                    r_dst_conf[i] <= bank_conf_out;
                end
            end
        end
    end

    // Sticky flag for strobes from ungranted sources or orphan bank results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if ((|(src_valid & ~r_grant)) || (bank_conf_out_valid && w_fifo_empty)) begin
            r_err <= 1'b1;
        end
    end

    assign grant              = r_grant;
    assign bank_disp_conf_in  = r_bin_disp;
    assign bank_conf_in       = r_bin_conf;
    assign bank_conf_in_valid = r_bin_valid;
    assign dst_disp_conf      = r_dst_disp;
    assign dst_conf           = r_dst_conf;
    assign dst_valid          = r_dst_valid;
    assign busy               = (r_state == ST_STREAM) || !w_fifo_empty;
    assign protocol_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_filter_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_bank_scheduler
// Description : Directed bench for filter_bank_scheduler with a line-level
//               reference model and hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_filter_bank_scheduler;

    localparam int c_disp_bits = 5;
    localparam int c_line_len  = 8;
    localparam int c_num_req   = 2;
    localparam int c_tag_depth = 4;
    localparam int c_cd_w      = 8 + c_disp_bits;
    localparam int c_echo_dly  = 20;

    logic                              clk = 1'b0;
    logic                              reset_n = 1'b0;
    logic [c_num_req-1:0]              req = '0;
    logic [c_num_req-1:0]              grant;
    logic [c_num_req-1:0][c_cd_w-1:0]  src_disp_conf = '0;
    logic [c_num_req-1:0][7:0]         src_conf = '0;
    logic [c_num_req-1:0]              src_valid = '0;
    logic [c_cd_w-1:0]                 bank_disp_conf_in;
    logic [7:0]                        bank_conf_in;
    logic                              bank_conf_in_valid;
    logic [c_cd_w-1:0]                 bank_disp_conf_out = '0;
    logic [7:0]                        bank_conf_out = '0;
    logic                              bank_conf_out_valid = 1'b0;
    logic [c_num_req-1:0][c_cd_w-1:0]  dst_disp_conf;
    logic [c_num_req-1:0][7:0]         dst_conf;
    logic [c_num_req-1:0]              dst_valid;
    logic                              busy;
    logic                              protocol_err;

    always #5 clk = ~clk;

    filter_bank_scheduler #(
        .disp_bits (c_disp_bits),
        .line_len  (c_line_len),
        .num_req   (c_num_req),
        .tag_depth (c_tag_depth)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .req                 (req),
        .grant               (grant),
        .src_disp_conf       (src_disp_conf),
        .src_conf            (src_conf),
        .src_valid           (src_valid),
        .bank_disp_conf_in   (bank_disp_conf_in),
        .bank_conf_in        (bank_conf_in),
        .bank_conf_in_valid  (bank_conf_in_valid),
        .bank_disp_conf_out  (bank_disp_conf_out),
        .bank_conf_out       (bank_conf_out),
        .bank_conf_out_valid (bank_conf_out_valid),
        .dst_disp_conf       (dst_disp_conf),
        .dst_conf            (dst_conf),
        .dst_valid           (dst_valid),
        .busy                (busy),
        .protocol_err        (protocol_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: line ownership, round-robin order and a queue of
    // lines in flight, stepped once per cycle with the inputs the DUT
    // will sample at the coming rising edge.
    // ------------------------------------------------------------------
    int                        m_owner = -1;
    int                        m_in_cnt = 0;
    int                        m_out_cnt = 0;
    int                        m_rr = 0;
    int                        m_tags[$];
    bit                        m_err = 1'b0;
    logic [c_num_req-1:0]      exp_grant = '0;
    bit                        exp_bin_v = 1'b0;
    logic [c_cd_w-1:0]         exp_bin_d = '0;
    logic [7:0]                exp_bin_c = '0;
    logic [c_num_req-1:0]      exp_dst_v = '0;
    logic [c_cd_w-1:0]         exp_dst_d = '0;
    logic [7:0]                exp_dst_c = '0;
    bit                        exp_busy = 1'b0;

    initial begin : p_compare
        int  pre_owner;
        int  pre_size;
        bit  do_push;
        bit  do_pop;
        bit  picked;
        forever begin
            @(negedge clk);
            // Compare what the last edge produced.
            chk("grant", 32'(grant), 32'(exp_grant));
            chk("bank_in_valid", 32'(bank_conf_in_valid), 32'(exp_bin_v));
            if (exp_bin_v) begin
                chk("bank_disp_in", 32'(bank_disp_conf_in), 32'(exp_bin_d));
                chk("bank_conf_in", 32'(bank_conf_in), 32'(exp_bin_c));
            end
            chk("dst_valid", 32'(dst_valid), 32'(exp_dst_v));
            for (int i = 0; i < c_num_req; i++) begin
                if (exp_dst_v[i]) begin
                    chk("dst_disp", 32'(dst_disp_conf[i]), 32'(exp_dst_d));
                    chk("dst_conf", 32'(dst_conf[i]), 32'(exp_dst_c));
                end
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("protocol_err", 32'(protocol_err), 32'(m_err));

            // Advance the model over the coming edge.
            if (!reset_n) begin
                m_owner = -1; m_in_cnt = 0; m_out_cnt = 0; m_rr = 0;
                m_tags.delete(); m_err = 1'b0;
                exp_grant = '0; exp_bin_v = 1'b0; exp_dst_v = '0;
            end else begin
                pre_owner = m_owner;
                pre_size  = m_tags.size();
                do_push   = 1'b0;
                do_pop    = 1'b0;
                exp_bin_v = 1'b0;
                exp_dst_v = '0;
                for (int i = 0; i < c_num_req; i++) begin
                    if (src_valid[i] && (i != pre_owner)) m_err = 1'b1;
                end
                if (pre_owner >= 0) begin
                    for (int i = 0; i < c_num_req; i++) begin
                        if (i == pre_owner && src_valid[i]) begin
                            exp_bin_v = 1'b1;
                            exp_bin_d = src_disp_conf[i];
                            exp_bin_c = src_conf[i];
                            m_in_cnt++;
                            if (m_in_cnt == c_line_len) begin
                                m_in_cnt  = 0;
                                do_push   = 1'b1;
                                m_owner   = -1;
                                exp_grant = '0;
                            end
                        end
                    end
                end else if (req != 0 && pre_size < c_tag_depth) begin
                    picked = 1'b0;
                    for (int k = 0; k < c_num_req; k++) begin
                        if (!picked && req[(m_rr + k) % c_num_req]) begin
                            picked    = 1'b1;
                            m_owner   = (m_rr + k) % c_num_req;
                            exp_grant = c_num_req'(1 << m_owner);
                        end
                    end
                    m_rr = (m_owner + 1) % c_num_req;
                end
                if (bank_conf_out_valid) begin
                    if (pre_size == 0) begin
                        m_err = 1'b1;
                    end else begin
                        exp_dst_v = c_num_req'(1 << m_tags[0]);
                        exp_dst_d = bank_disp_conf_out;
                        exp_dst_c = bank_conf_out;
                        m_out_cnt++;
                        if (m_out_cnt == c_line_len) begin
                            m_out_cnt = 0;
                            do_pop    = 1'b1;
                        end
                    end
                end
                if (do_pop)  void'(m_tags.pop_front());
                if (do_push) m_tags.push_back(pre_owner);
            end
            exp_busy = (m_owner >= 0) || (m_tags.size() > 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus side: auto-streaming requesters, a delayed bank echo and
    // logs of observed behaviour for the literal checks.
    // ------------------------------------------------------------------
    bit                    stream_en = 1'b1;
    bit                    echo_en   = 1'b0;
    bit                    man_v     = 1'b0;
    logic [7:0]            man_c     = '0;
    logic [c_num_req-1:0]  inj       = '0;
    int                    pix [c_num_req];
    logic [c_cd_w+8:0]     pipe [c_echo_dly];
    logic [c_num_req-1:0]  prev_grant = '0;
    logic [c_num_req-1:0]  grant_log[$];
    int                    len_log[$];
    int                    gap_log[$];
    int                    g_len = 0;
    int                    z_len = 0;
    logic [7:0]            dst1_log[$];
    int                    dst_cnt [c_num_req];
    int                    ee_seen = 0;

    task automatic clear_logs();
        grant_log.delete(); len_log.delete(); gap_log.delete(); dst1_log.delete();
        g_len = 0; z_len = 0; ee_seen = 0;
        for (int i = 0; i < c_num_req; i++) begin
            pix[i] = 1;
            dst_cnt[i] = 0;
        end
        for (int k = 0; k < c_echo_dly; k++) pipe[k] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (grant != 0 && prev_grant == 0) begin
            grant_log.push_back(grant);
            if (grant_log.size() > 1) gap_log.push_back(z_len);
        end
        if (grant != 0) begin
            g_len++;
            z_len = 0;
        end else begin
            if (prev_grant != 0) begin
                len_log.push_back(g_len);
                g_len = 0;
            end
            z_len++;
        end
        prev_grant = grant;
        for (int i = 0; i < c_num_req; i++) begin
            if (dst_valid[i]) begin
                dst_cnt[i]++;
                if (i == 1) dst1_log.push_back(dst_conf[i]);
            end
        end
        if (bank_conf_in_valid && bank_conf_in == 8'hEE) ee_seen++;
        for (int i = 0; i < c_num_req; i++) begin
            src_valid[i] = 1'b0;
            if (grant[i] && stream_en) begin
                src_valid[i]     = 1'b1;
                src_conf[i]      = 8'(pix[i]);
                src_disp_conf[i] = {5'(i), 8'(pix[i])};
                pix[i]++;
            end else if (inj[i]) begin
                src_valid[i]     = 1'b1;
                src_conf[i]      = 8'hEE;
                src_disp_conf[i] = {5'h1F, 8'hEE};
            end
        end
        for (int k = c_echo_dly - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = echo_en ? {bank_conf_in_valid, bank_disp_conf_in, bank_conf_in} : '0;
        if (man_v) begin
            bank_conf_out_valid = 1'b1;
            bank_disp_conf_out  = {5'h3, man_c};
            bank_conf_out       = man_c;
        end else begin
            {bank_conf_out_valid, bank_disp_conf_out, bank_conf_out} = pipe[c_echo_dly-1];
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0; inj = '0; echo_en = 1'b0; man_v = 1'b0;
        clear_logs();
        tick();
        tick();
        reset_n = 1'b1;
        clear_logs();
        prev_grant = '0;
    endtask

    task automatic wait_grant(input string name, input int budget);
        int n;
        n = 0;
        while (grant == 0 && n < budget) begin
            tick();
            n++;
        end
        if (grant == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no-grant required=grant within %0d cycles", name, budget);
        end
    endtask

    initial begin : p_main
        for (int k = 0; k < c_echo_dly; k++) pipe[k] = '0;
        clear_logs();
        tick();
        tick();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_err", 32'(protocol_err), 32'h0);
        do_reset();

        // Single line from requester 1 echoed by the bank after 20 cycles.
        echo_en = 1'b1;
        req = 2'b10;
        wait_grant("t035_grant", 10);
        req = '0;
        chk("t035_grant", 32'(grant), 32'h2);
        repeat (45) tick();
        chk("t035_dst1_count", 32'(dst_cnt[1]), 32'd8);
        chk("t035_dst0_count", 32'(dst_cnt[0]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k < dst1_log.size()) chk("t035_dst1_data", 32'(dst1_log[k]), 32'(k + 1));
        end
        chk("t035_idle_busy", 32'(busy), 32'h0);

        // Both requesters held: alternating one-line grants with a gap.
        do_reset();
        echo_en = 1'b1;
        req = 2'b11;
        for (int n = 0; n < 40 && grant_log.size() < 3; n++) tick();
        req = '0;
        repeat (50) tick();
        chk("t034_num_grants", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() >= 3) begin
            chk("t034_grant0", 32'(grant_log[0]), 32'h1);
            chk("t034_grant1", 32'(grant_log[1]), 32'h2);
            chk("t034_grant2", 32'(grant_log[2]), 32'h1);
        end
        for (int k = 0; k < len_log.size(); k++) chk("t034_grant_len", 32'(len_log[k]), 32'd8);
        for (int k = 0; k < gap_log.size(); k++) chk("t034_gap", 32'(gap_log[k]), 32'd1);

        // Bank withholds results: tag FIFO fills after four lines.
        do_reset();
        req = 2'b11;
        repeat (60) tick();
        chk("t036_num_grants", 32'(grant_log.size()), 32'd4);
        chk("t036_grant_held", 32'(grant), 32'h0);
        chk("t036_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 8; k++) begin
            man_v = 1'b1;
            man_c = 8'(8'h40 + k);
            tick();
        end
        man_v = 1'b0;
        man_c = '0;
        tick();
        chk("t036_still_held", 32'(grant_log.size()), 32'd4);
        wait_grant("t036_regrant", 10);
        chk("t036_regrant", 32'(grant), 32'h1);
        chk("t036_dst0_count", 32'(dst_cnt[0]), 32'd8);

        // Ungranted strobe is dropped and flagged until reset.
        do_reset();
        req = 2'b10;
        wait_grant("t037_grant", 10);
        req = '0;
        tick();
        inj = 2'b01;
        tick();
        inj = '0;
        repeat (15) tick();
        chk("t037_err", 32'(protocol_err), 32'h1);
        chk("t037_dropped", 32'(ee_seen), 32'd0);

        // Reset in the middle of a line owned by requester 0.
        do_reset();
        chk("t037_err_cleared", 32'(protocol_err), 32'h0);
        req = 2'b11;
        wait_grant("t038_grant", 10);
        chk("t038_first_owner", 32'(grant), 32'h1);
        inj = 2'b10;
        tick();
        inj = '0;
        for (int n = 0; n < 10 && pix[0] < 6; n++) tick();
        reset_n = 1'b0;
        tick();
        chk("t038_grant_cleared", 32'(grant), 32'h0);
        chk("t038_busy_cleared", 32'(busy), 32'h0);
        chk("t038_err_cleared", 32'(protocol_err), 32'h0);
        reset_n = 1'b1;
        wait_grant("t038_regrant", 10);
        chk("t038_regrant", 32'(grant), 32'h1);
        req = '0;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
